// File: rtl/rda_subtractor32.sv
// rda_subtractor32: 3-stage pipelined 32-bit subtractor, a - b - bin computed
// as a + ~b + ~bin through a KPG Kogge-Stone prefix tree.
// Ports: clk, rst (async, active-low); in_valid/in_ready with a, b, bin;
// out_valid/out_ready with diff, bout, zero, neg, ovf.
module rda_subtractor32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        neg,
  output logic        ovf
);

  localparam logic [1:0] K = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] G = 2'b11;

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // S1: operand capture, b and bin already inverted
  logic [31:0] a1;
  logic [31:0] bp1;
  logic        c01;
  logic        v1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1  <= '0;
      bp1 <= '0;
      c01 <= 1'b0;
      v1  <= 1'b0;
    end else if (advance) begin
      a1  <= a;
      bp1 <= ~b;
      c01 <= ~bin;
      v1  <= in_valid;
    end
  end

  // S2: prefix tree. Index 0 is position -1 (carry-in), index i+1 is bit i.
  logic [1:0]  pre [0:5][0:32];
  logic [1:0]  top;
  logic [32:0] c;

  assign pre[0][0] = c01 ? G : K;

  for (genvar i = 0; i < 32; i++) begin : g_kpg
    // {a&b', a|b'} maps 00->k, 01/10->p, 11->g
    assign pre[0][i+1] = {a1[i] & bp1[i], a1[i] | bp1[i]};
  end

  for (genvar l = 0; l < 5; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar j = 0; j < 33; j++) begin : g_node
      if (j >= D) begin : g_cmb
        assign pre[l+1][j] =
          (pre[l][j] == P) ? pre[l][j-D] : pre[l][j];
      end else begin : g_pass
        assign pre[l+1][j] = pre[l][j];
      end
    end
  end

  // Five levels span 32 positions; the top node still lacks the
  // carry-in position, so fold it in once more.
  assign top = (pre[5][32] == P) ? pre[5][0] : pre[5][32];

  for (genvar i = 0; i < 32; i++) begin : g_carry
    assign c[i] = (pre[5][i] == G);
  end
  assign c[32] = (top == G);

  logic [31:0] p2;
  logic [32:0] c2;
  logic        a31_2;
  logic        v2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p2    <= '0;
      c2    <= '0;
      a31_2 <= 1'b0;
      v2    <= 1'b0;
    end else if (advance) begin
      p2    <= a1 ^ bp1;
      c2    <= c;
      a31_2 <= a1[31];
      v2    <= v1;
    end
  end

  // S3: sum and flags
  logic [31:0] d3;

  assign d3 = p2 ^ c2[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      diff      <= d3;
      bout      <= ~c2[32];
      zero      <= (d3 == 32'd0);
      neg       <= d3[31];
      // a[31] != b[31] is the same as a[31] == b'[31], i.e. no propagate
      ovf       <= ~p2[31] & (d3[31] ^ a31_2);
      out_valid <= v2;
    end
  end

endmodule

// File: tb/tb_rda_subtractor32.sv
// tb_rda_subtractor32: directed and randomized checks of rda_subtractor32.
// Drives and samples on the falling clock edge.
module tb_rda_subtractor32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bout, zero, neg, ovf;

  logic [35:0] obs;
  assign obs = {bout, zero, neg, ovf, diff};

  int checks = 0;
  int failures = 0;

  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  rda_subtractor32 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero),
    .neg(neg), .ovf(ovf)
  );

  function automatic logic [35:0] model(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic c);
    logic [32:0] f;
    logic [31:0] d;
    f = {1'b0, x} - {1'b0, y} - {32'd0, c};
    d = f[31:0];
    return {f[32], d == 32'd0, d[31],
            (x[31] != y[31]) && (d[31] != x[31]), d};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    a = 32'd5;
    b = 32'd1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    checks++;
    if (obs !== 36'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 32'h0000_000A;
    b = 32'h0000_0003;
    bin = 1'b0;
    @(negedge clk);
    a = 32'h0;
    b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_valid got=%b want=1", out_valid);
    end
    checks++;
    if (diff !== 32'h0000_0007) begin
      failures++;
      $display("FAIL basic_diff got=%h want=00000007", diff);
    end
    checks++;
    if ({bout, zero, neg, ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL basic_flags got=%b want=0000",
               {bout, zero, neg, ovf});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL borrow_valid got=%b want=1", out_valid);
    end
    checks++;
    if (diff !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL borrow_diff got=%h want=ffffffff", diff);
    end
    checks++;
    if ({bout, zero, neg, ovf} !== 4'b1010) begin
      failures++;
      $display("FAIL borrow_flags got=%b want=1010",
               {bout, zero, neg, ovf});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_borrow_zero();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 32'h8000_0000;
    b = 32'h7FFF_FFFF;
    bin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || diff !== 32'h0) begin
      failures++;
      $display("FAIL bin_zero_diff got=%b/%h want=1/00000000",
               out_valid, diff);
    end
    checks++;
    if ({bout, zero, neg, ovf} !== 4'b0101) begin
      failures++;
      $display("FAIL bin_zero_flags got=%b want=0101",
               {bout, zero, neg, ovf});
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 32'h7FFF_FFFF;
    b = 32'hFFFF_FFFF;
    bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || diff !== 32'h8000_0000) begin
      failures++;
      $display("FAIL ovf_diff got=%b/%h want=1/80000000",
               out_valid, diff);
    end
    checks++;
    if ({bout, zero, neg, ovf} !== 4'b1011) begin
      failures++;
      $display("FAIL ovf_flags got=%b want=1011",
               {bout, zero, neg, ovf});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] va [5] = '{32'd100, 32'd5, 32'hFFFF_FFFF,
                            32'h1234_5678, 32'h0};
    logic [31:0] vb [5] = '{32'd1, 32'd5, 32'hFFFF_FFFE,
                            32'h0234_5678, 32'hFFFF_FFFF};
    logic        vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ed [5] = '{32'h63, 32'hFFFF_FFFF, 32'h0,
                            32'h1000_0000, 32'h0};
    logic        eb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          idx_q [$];
    int          sent = 0;
    int          got = 0;
    int          idx;
    logic        stalled = 1'b0;
    logic [35:0] held = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      out_ready = !(k >= 4 && k <= 6);
      in_valid = (sent < 5);
      if (sent < 5) begin
        a = va[sent];
        b = vb[sent];
        bin = vc[sent];
      end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++;
        $display("FAIL bp_in_ready k=%0d got=%b ov=%b or=%b",
                 k, in_ready, out_valid, out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held) begin
          failures++;
          $display("FAIL bp_stable k=%0d got=%h want=%h",
                   k, obs, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (idx_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra k=%0d got=%h want=none", k, diff);
        end else begin
          idx = idx_q.pop_front();
          got++;
          if (diff !== ed[idx] || bout !== eb[idx]) begin
            failures++;
            $display("FAIL bp_result op=%0d got=%h/%b want=%h/%b",
                     idx, diff, bout, ed[idx], eb[idx]);
          end
        end
      end
      if (in_valid && in_ready) begin
        idx_q.push_back(sent);
        sent++;
      end
      stalled = out_valid && !out_ready;
      held = obs;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5 || idx_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count got=%0d want=5", got);
    end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [35:0] held = '0;
    logic [35:0] e;
    exp_q.delete();
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!stalled || !in_valid) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        a = rnd_word();
        b = rnd_word();
        bin = $urandom_range(0, 1) != 0;
      end
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready cyc=%0d got=%b", cyc, in_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held) begin
          failures++;
          $display("FAIL rnd_stable cyc=%0d got=%h want=%h",
                   cyc, obs, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra cyc=%0d got=%h", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (obs !== e) begin
            failures++;
            $display("FAIL rnd_result n=%0d got=%h want=%h",
                     got, obs, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        sent++;
      end
      stalled = out_valid && !out_ready;
      held = obs;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 10000 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_done sent=%0d left=%0d want=10000/0",
               sent, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int          got = 0;
    int          sent = 0;
    logic [35:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h1000 + k;
      b = 32'h10;
      bin = 1'b0;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== 36'h0) begin
      failures++;
      $display("FAIL mid_reset_async got=%b/%h want=0/0",
               out_valid, obs);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid = (sent < 8);
      a = 32'hA000 + k;
      b = 32'h0000_0F0F;
      bin = k[0];
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mid_reset_stale k=%0d got=%h", k, obs);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (obs !== e) begin
            failures++;
            $display("FAIL mid_reset_result n=%0d got=%h want=%h",
                     got, obs, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_count got=%0d want=8", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_zero();
    test_overflow();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
